// File: rtl/hazard_fwd_unit_if.sv
// Hazard/forwarding unit bus: decode-stage register fields and the EX branch
// decision towards the unit, operand-select and stall/flush controls back.
interface hazard_fwd_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int PERF_CNT_W = 32
);
  logic [REG_ADDR_W-1:0] rs1_d;
  logic [REG_ADDR_W-1:0] rs2_d;
  logic [REG_ADDR_W-1:0] rd_d;
  logic                  regwrite_d;
  logic                  load_d;
  logic                  pcsrc_e;
  logic [1:0]            forward_a_e;
  logic [1:0]            forward_b_e;
  logic                  stall_f;
  logic                  stall_d;
  logic                  flush_d;
  logic                  flush_e;
  logic [PERF_CNT_W-1:0] stall_cnt;
  logic [PERF_CNT_W-1:0] flush_cnt;

  // Pipeline side: supplies register fields, consumes controls.
  modport master (
    output rs1_d, rs2_d, rd_d, regwrite_d, load_d, pcsrc_e,
    input  forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e,
    input  stall_cnt, flush_cnt
  );

  // Hazard unit side.
  modport slave (
    input  rs1_d, rs2_d, rd_d, regwrite_d, load_d, pcsrc_e,
    output forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding control for a 5-stage pipeline.
// Keeps E/M/W shadow copies of register usage, drives the ALU operand
// select muxes, and raises load-use stalls and branch flushes.
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush counters;
// without it the counter outputs are tied to zero.
module hazard_fwd_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int PERF_CNT_W = 32
) (
  input logic               clk,
  input logic               rst,
  hazard_fwd_unit_if.slave  bus
);

  logic [REG_ADDR_W-1:0] rs1_e, rs2_e, rd_e;
  logic                  regwrite_e, load_e;
  logic [REG_ADDR_W-1:0] rd_m;
  logic                  regwrite_m;
  logic [REG_ADDR_W-1:0] rd_w;
  logic                  regwrite_w;
  logic                  lwstall;
  logic                  bubble_e;

  // Load-use hazard: load in E whose destination feeds the decode instruction,
  // suppressed when a taken branch already kills the decode instruction.
  always_comb begin
    lwstall = load_e && (rd_e != '0) &&
              ((rd_e == bus.rs1_d) || (rd_e == bus.rs2_d)) && !bus.pcsrc_e;
    bubble_e = lwstall || bus.pcsrc_e;
  end

  // Stall/flush controls; reset holds both pipeline registers cleared.
  always_comb begin
    bus.stall_f = lwstall && !rst;
    bus.stall_d = lwstall && !rst;
    bus.flush_d = bus.pcsrc_e || rst;
    bus.flush_e = bubble_e || rst;
  end

  // Operand selects from shadow state only; M (newest producer) wins over W.
  always_comb begin
    bus.forward_a_e = 2'b00;
    bus.forward_b_e = 2'b00;
    if (rs1_e != '0) begin
      if (regwrite_m && (rd_m == rs1_e))      bus.forward_a_e = 2'b10;
      else if (regwrite_w && (rd_w == rs1_e)) bus.forward_a_e = 2'b01;
    end
    if (rs2_e != '0) begin
      if (regwrite_m && (rd_m == rs2_e))      bus.forward_b_e = 2'b10;
      else if (regwrite_w && (rd_w == rs2_e)) bus.forward_b_e = 2'b01;
    end
  end

  // Shadow pipe D->E->M->W; E takes a bubble on stall or branch flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_e      <= '0;
      rs2_e      <= '0;
      rd_e       <= '0;
      regwrite_e <= 1'b0;
      load_e     <= 1'b0;
      rd_m       <= '0;
      regwrite_m <= 1'b0;
      rd_w       <= '0;
      regwrite_w <= 1'b0;
    end else begin
      rd_w       <= rd_m;
      regwrite_w <= regwrite_m;
      rd_m       <= rd_e;
      regwrite_m <= regwrite_e;
      if (bubble_e) begin
        rs1_e      <= '0;
        rs2_e      <= '0;
        rd_e       <= '0;
        regwrite_e <= 1'b0;
        load_e     <= 1'b0;
      end else begin
        rs1_e      <= bus.rs1_d;
        rs2_e      <= bus.rs2_d;
        rd_e       <= bus.rd_d;
        regwrite_e <= bus.regwrite_d;
        load_e     <= bus.load_d;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  localparam logic [PERF_CNT_W-1:0] CNT_ONE = PERF_CNT_W'(1);
  logic [PERF_CNT_W-1:0] stall_q, flush_q;

  // Saturating event counters: load-use stall cycles and taken-branch flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (lwstall && (stall_q != '1))     stall_q <= stall_q + CNT_ONE;
      if (bus.pcsrc_e && (flush_q != '1)) flush_q <= flush_q + CNT_ONE;
    end
  end

  // Counter outputs.
  always_comb begin
    bus.stall_cnt = stall_q;
    bus.flush_cnt = flush_q;
  end
`else
  // Counters not built.
  always_comb begin
    bus.stall_cnt = '0;
    bus.flush_cnt = '0;
  end
`endif

endmodule
